// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage of the 16-bit pipeline.
package fetch_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP_INSTR    = 16'h0000;
  localparam pc_t    RESET_PC_DEF = 16'h0000;

  typedef struct packed {
    logic   valid;
    instr_t instr;
    pc_t    pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    SRC_BUBBLE,
    SRC_PEND,
    SRC_SKID
  } out_src_e;

  // Sequential successor; wraps 16'hFFFF -> 16'h0000 through natural truncation.
  function automatic pc_t pc_next(input pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/fetch_skid_entry.sv
// Single-entry {valid, instr, pc} holder that parks a fetched instruction while IF/ID is stalled.
module fetch_skid_entry
  import fetch_pkg::*;
(
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   capture_i,
  input  logic   release_i,
  input  logic   flush_i,
  input  instr_t instr_i,
  input  pc_t    pc_i,
  output logic   valid_o,
  output instr_t instr_o,
  output pc_t    pc_o
);

  fetch_entry_t entry_q, entry_d;

  // Flush beats capture so a redirect can never leave a stale entry behind.
  always_comb begin
    entry_d = entry_q;
    if (flush_i) begin
      entry_d.valid = 1'b0;
    end else if (capture_i) begin
      entry_d.valid = 1'b1;
      entry_d.instr = instr_i;
      entry_d.pc    = pc_i;
    end else if (release_i) begin
      entry_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      entry_q.valid <= 1'b0;
      entry_q.instr <= NOP_INSTR;
      entry_q.pc    <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign valid_o = entry_q.valid;
  assign instr_o = entry_q.instr;
  assign pc_o    = entry_q.pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, 1-cycle-latency imem requests, IF/ID drive, stall skid and redirect squash.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter pc_t    RESET_PC = RESET_PC_DEF,
  parameter instr_t NOP      = NOP_INSTR
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   stall_i,
  input  logic   redirect_i,
  input  pc_t    redirect_pc_i,
  output logic   imem_en_o,
  output pc_t    imem_addr_o,
  input  instr_t imem_rdata_i,
  output instr_t fetch_instr_o,
  output pc_t    fetch_pc_o,
  output logic   fetch_valid_o,
  output logic   ifid_ld_o
);

  pc_t  pc_q, pc_d;
  logic pend_q, pend_d;
  pc_t  pend_pc_q, pend_pc_d;

  logic   skid_valid;
  instr_t skid_instr;
  pc_t    skid_pc;
  logic   skid_capture;
  logic   skid_release;

  out_src_e src;
  logic     src_valid;
  instr_t   src_instr;
  pc_t      src_pc;

  always_comb begin
    imem_en_o   = !reset_i && (redirect_i || !stall_i);
    imem_addr_o = redirect_i ? redirect_pc_i : pc_q;
  end

  always_comb begin
    pc_d      = pc_q;
    pend_d    = 1'b0;
    pend_pc_d = pend_pc_q;
    if (imem_en_o) begin
      pc_d      = pc_next(imem_addr_o);
      pend_d    = 1'b1;
      pend_pc_d = imem_addr_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= RESET_PC;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Park the pending response whenever IF/ID cannot take it this cycle.
  assign skid_capture = pend_q && (stall_i || skid_valid);
  assign skid_release = !stall_i;

  fetch_skid_entry u_skid (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .capture_i (skid_capture),
    .release_i (skid_release),
    .flush_i   (redirect_i),
    .instr_i   (imem_rdata_i),
    .pc_i      (pend_pc_q),
    .valid_o   (skid_valid),
    .instr_o   (skid_instr),
    .pc_o      (skid_pc)
  );

  always_comb begin
    if (skid_valid) begin
      src = SRC_SKID;
    end else if (pend_q) begin
      src = SRC_PEND;
    end else begin
      src = SRC_BUBBLE;
    end
  end

  always_comb begin
    src_valid = 1'b0;
    src_instr = NOP;
    src_pc    = pc_q;
    case (src)
      SRC_SKID: begin
        src_valid = 1'b1;
        src_instr = skid_instr;
        src_pc    = skid_pc;
      end
      SRC_PEND: begin
        src_valid = 1'b1;
        src_instr = imem_rdata_i;
        src_pc    = pend_pc_q;
      end
      default: begin
        src_valid = 1'b0;
      end
    endcase
  end

  // Reset forces the IF/ID inputs to their idle values even while old state is still live.
  always_comb begin
    fetch_valid_o = !reset_i && src_valid && !redirect_i;
    fetch_instr_o = fetch_valid_o ? src_instr : NOP;
    fetch_pc_o    = reset_i ? RESET_PC : src_pc;
    ifid_ld_o     = reset_i || !stall_i || redirect_i;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: accepted IF/ID loads are scored against a queue of expected PCs.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;

  logic        imem_en, imem_en_w;
  logic [15:0] imem_addr, imem_addr_w;
  logic [15:0] imem_rdata, imem_rdata_w;
  logic [15:0] fetch_instr, fetch_instr_w;
  logic [15:0] fetch_pc, fetch_pc_w;
  logic        fetch_valid, fetch_valid_w;
  logic        ifid_ld, ifid_ld_w;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  fetch_stage dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_en_o     (imem_en),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .fetch_instr_o (fetch_instr),
    .fetch_pc_o    (fetch_pc),
    .fetch_valid_o (fetch_valid),
    .ifid_ld_o     (ifid_ld)
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) dut_w (
    .clk_i         (clk),
    .reset_i       (reset),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_en_o     (imem_en_w),
    .imem_addr_o   (imem_addr_w),
    .imem_rdata_i  (imem_rdata_w),
    .fetch_instr_o (fetch_instr_w),
    .fetch_pc_o    (fetch_pc_w),
    .fetch_valid_o (fetch_valid_w),
    .ifid_ld_o     (ifid_ld_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: word at address a holds a + 16'h1000.
  initial begin
    imem_rdata   = 16'h0;
    imem_rdata_w = 16'h0;
  end
  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= imem_addr + 16'h1000;
    if (imem_en_w) imem_rdata_w <= imem_addr_w + 16'h1000;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_en"},     16'(imem_en),     16'h0);
    chk({tag, "_ifid_ld"},     16'(ifid_ld),     16'h1);
    chk({tag, "_fetch_valid"}, 16'(fetch_valid), 16'h0);
    chk({tag, "_fetch_instr"}, fetch_instr,      16'h0000);
    chk({tag, "_fetch_pc"},    fetch_pc,         16'h0000);
  endtask

  // Scoreboard: every instruction actually loaded into IF/ID must be the next expected one.
  always @(negedge clk) begin
    if (!reset && ifid_ld && fetch_valid) begin
      chk("sb_expected_present", 16'(exp_q.size() != 0), 16'h1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", fetch_pc, e);
        chk("sb_instr", fetch_instr, e + 16'h1000);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    stall       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0;

    cyc(); cyc();
    mid();
    chk_reset_outputs("rst");
    chk("rst_wrap_pc", fetch_pc_w, 16'hFFFE);

    // cycle 0 after release
    cyc(); reset = 1'b0; stall = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(i));
    mid();
    chk("c0_imem_en", 16'(imem_en), 16'h1);
    chk("c0_imem_addr", imem_addr, 16'h0000);
    chk("c0_bubble", 16'(fetch_valid), 16'h0);
    chk("c0_wrap_addr", imem_addr_w, 16'hFFFE);

    cyc(); mid();
    chk("c1_first_valid", 16'(fetch_valid), 16'h1);
    chk("wrap_pc0", fetch_pc_w, 16'hFFFE);
    chk("wrap_instr0", fetch_instr_w, 16'h0FFE);
    cyc(); mid();
    chk("wrap_pc1", fetch_pc_w, 16'hFFFF);
    cyc(); mid();
    chk("wrap_pc2", fetch_pc_w, 16'h0000);
    chk("wrap_valid2", 16'(fetch_valid_w), 16'h1);
    cyc(); cyc();

    // cycles 6..8: stall while pc 5 is pending
    cyc(); stall = 1'b1;
    mid();
    chk("st0_ifid_ld", 16'(ifid_ld), 16'h0);
    chk("st0_imem_en", 16'(imem_en), 16'h0);
    for (int i = 1; i < 3; i++) begin
      cyc(); mid();
      chk("st_ifid_ld", 16'(ifid_ld), 16'h0);
      chk("st_imem_en", 16'(imem_en), 16'h0);
      chk("st_skid_pc", fetch_pc, 16'h0005);
    end

    // cycle 9: release presents the held instruction
    cyc(); stall = 1'b0;
    mid();
    chk("rel_pc", fetch_pc, 16'h0005);
    chk("rel_ifid_ld", 16'(ifid_ld), 16'h1);
    cyc(); cyc();

    // cycles 12..13: fill the skid with pc 8
    cyc(); stall = 1'b1;
    cyc(); mid();
    chk("skid8_pc", fetch_pc, 16'h0008);

    // cycle 14: redirect with skid full
    cyc(); stall = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
    exp_q.push_back(16'h0040);
    mid();
    chk("rd_valid", 16'(fetch_valid), 16'h0);
    chk("rd_instr", fetch_instr, 16'h0000);
    chk("rd_ifid_ld", 16'(ifid_ld), 16'h1);
    chk("rd_imem_addr", imem_addr, 16'h0040);

    cyc(); redirect = 1'b0;
    mid();
    chk("rd_target_pc", fetch_pc, 16'h0040);

    // cycle 16: redirect together with stall
    cyc(); stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
    exp_q.push_back(16'h0080);
    exp_q.push_back(16'h0081);
    mid();
    chk("rs_ifid_ld", 16'(ifid_ld), 16'h1);
    chk("rs_valid", 16'(fetch_valid), 16'h0);
    chk("rs_imem_en", 16'(imem_en), 16'h1);
    chk("rs_imem_addr", imem_addr, 16'h0080);

    cyc(); stall = 1'b0; redirect = 1'b0;
    cyc();

    // cycles 19..21: stall fills skid, then reset mid-stall
    cyc(); stall = 1'b1;
    cyc(); reset = 1'b1;
    cyc(); mid();
    chk_reset_outputs("mid_rst");

    cyc(); reset = 1'b0; stall = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(16'(i));
    mid();
    chk("restart_imem_en", 16'(imem_en), 16'h1);
    chk("restart_imem_addr", imem_addr, 16'h0000);
    chk("restart_bubble", 16'(fetch_valid), 16'h0);
    cyc(); cyc(); cyc();

    cyc(); stall = 1'b1;
    cyc(); cyc();
    chk("sb_drained", 16'(exp_q.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
